// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative signed multiply/divide unit for the execute stage. Owns the
//   architectural HI/LO registers, runs a WIDTH-cycle shift-add multiply or
//   restoring divide, and requests pipeline stalls while busy.
// Ports:
//   clk, flush          clock (rising edge) / async active-high clear
//   Start_EX, IsDiv_EX  launch an op; 1 = div, 0 = mult
//   SrcA_EX, SrcB_EX    operands (SrcA also feeds mthi/mtlo)
//   MfReq_EX            mfhi/mflo waiting in execute
//   MtHi_EX, MtLo_EX    write SrcA_EX into HI / LO
//   Hi, Lo              architectural HI / LO
//   Busy                operation in flight
//   MdStall             combinational stall request
//   Done, DivByZero     one-cycle completion pulses
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             flush,
    input  logic             Start_EX,
    input  logic             IsDiv_EX,
    input  logic [WIDTH-1:0] SrcA_EX,
    input  logic [WIDTH-1:0] SrcB_EX,
    input  logic             MfReq_EX,
    input  logic             MtHi_EX,
    input  logic             MtLo_EX,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             MdStall,
    output logic             Done,
    output logic             DivByZero
);

    typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

    state_t             state;
    logic [CNTW-1:0]    cnt;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               sign_a, sign_b, is_div, div_zero;
    // Mult: {partial product, remaining multiplier bits}.
    // Div:  {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [2*WIDTH-1:0] prod;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_trial;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH-1:0]   abs_a, abs_b;

    // Magnitude of the most-negative value wraps to itself, which read as
    // unsigned is exactly 2^(WIDTH-1).
    assign abs_a = SrcA_EX[WIDTH-1] ? -SrcA_EX : SrcA_EX;
    assign abs_b = SrcB_EX[WIDTH-1] ? -SrcB_EX : SrcB_EX;

    assign mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod[0]}} & a_mag};
    // Remainder stays below the divisor (<= 2^(WIDTH-1)), so the shifted value
    // fits in WIDTH bits and the top bit of the trial is a clean borrow.
    assign div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, b_mag};

    always_comb begin
        prod_step = {mul_sum, prod[WIDTH-1:1]};
        if (is_div) begin
            if (!div_trial[WIDTH])
                prod_step = {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
            else
                prod_step = {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
        end
    end

    assign Busy    = (state != IDLE);
    assign MdStall = Busy & (Start_EX | MfReq_EX | MtHi_EX | MtLo_EX);

    always_ff @(posedge clk or posedge flush) begin
        if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_div    <= 1'b0;
            div_zero  <= 1'b0;
            prod      <= '0;
            Hi        <= '0;
            Lo        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start_EX) begin
                        a_mag    <= abs_a;
                        b_mag    <= abs_b;
                        sign_a   <= SrcA_EX[WIDTH-1];
                        sign_b   <= SrcB_EX[WIDTH-1];
                        is_div   <= IsDiv_EX;
                        div_zero <= IsDiv_EX && (SrcB_EX == '0);
                        prod     <= {{WIDTH{1'b0}}, IsDiv_EX ? abs_a : abs_b};
                        cnt      <= '0;
                        state    <= RUN;
                    end else begin
                        // Start takes priority; Mt writes only land when no op launches.
                        if (MtHi_EX) Hi <= SrcA_EX;
                        if (MtLo_EX) Lo <= SrcA_EX;
                    end
                end
                RUN: begin
                    prod <= prod_step;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNTW'(WIDTH-1)) state <= FIXUP;
                end
                FIXUP: begin
                    if (div_zero) begin
                        Lo <= '1;
                        Hi <= sign_a ? -a_mag : a_mag;   // rebuilds original SrcA
                    end else if (is_div) begin
                        Lo <= (sign_a ^ sign_b) ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
                        Hi <= sign_a ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
                    end else begin
                        {Hi, Lo} <= (sign_a ^ sign_b) ? -prod : prod;
                    end
                    Done      <= 1'b1;
                    DivByZero <= div_zero;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written
// corner sequences, and random ops checked against a plain-arithmetic model.
module tb_muldiv_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         flush;
    logic         Start_EX, IsDiv_EX, MfReq_EX, MtHi_EX, MtLo_EX;
    logic [W-1:0] SrcA_EX, SrcB_EX;
    logic [W-1:0] Hi, Lo;
    logic         Busy, MdStall, Done, DivByZero;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.WIDTH(W), .CNTW(6)) dut (
        .clk(clk), .flush(flush), .Start_EX(Start_EX), .IsDiv_EX(IsDiv_EX),
        .SrcA_EX(SrcA_EX), .SrcB_EX(SrcB_EX), .MfReq_EX(MfReq_EX),
        .MtHi_EX(MtHi_EX), .MtLo_EX(MtLo_EX), .Hi(Hi), .Lo(Lo), .Busy(Busy),
        .MdStall(MdStall), .Done(Done), .DivByZero(DivByZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         is_div;
        logic [W-1:0] a, b;
        logic [W-1:0] exp_hi, exp_lo;
        logic         exp_dz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed arithmetic in 64 bits, straight from the op definitions.
    task automatic model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        if (!is_div) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 0) begin
            dz = 1'b1;
            hi = a;
            lo = '1;
        end else begin
            q  = sa / sb;   // truncates toward zero, remainder takes dividend sign
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endtask

    // Launch an op at a negedge; returns at the negedge of the Done cycle
    // (or after the budget expires). lat = cycles after the start edge.
    task automatic run_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cnt, output logic dz);
        Start_EX = 1'b1; IsDiv_EX = is_div; SrcA_EX = a; SrcB_EX = b;
        @(posedge clk);
        @(negedge clk);
        Start_EX = 1'b0;
        lat = -1; busy_cnt = 0; dz = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (Busy) busy_cnt++;
            if (Done) begin
                lat = c; dz = DivByZero;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            errors++;
            $display("FAIL timeout: no Done within 40 cycles (a=%h b=%h)", a, b);
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [W-1:0] eh, el;
        logic         edz, dz;
        int           lat, bc;

        vecs[0] = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_000E, 1'b0};
        vecs[7] = '{1'b1, 32'hFFFF_FFF6, 32'h0000_0000, 32'hFFFF_FFF6, 32'hFFFF_FFFF, 1'b1};

        flush = 1'b1; Start_EX = 0; IsDiv_EX = 0; MfReq_EX = 0; MtHi_EX = 0; MtLo_EX = 0;
        SrcA_EX = '0; SrcB_EX = '0;
        #12;
        check("reset_hi", Hi, 0);
        check("reset_lo", Lo, 0);
        check("reset_busy_done_dz", {Busy, Done, DivByZero}, 0);
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);

        // Directed table.
        foreach (vecs[i]) begin
            run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, lat, bc, dz);
            check($sformatf("vec%0d_latency", i), lat, 34);
            check($sformatf("vec%0d_busy_cycles", i), bc, 33);
            check($sformatf("vec%0d_hi", i), Hi, vecs[i].exp_hi);
            check($sformatf("vec%0d_lo", i), Lo, vecs[i].exp_lo);
            check($sformatf("vec%0d_dz", i), dz, vecs[i].exp_dz);
            @(negedge clk);
            check($sformatf("vec%0d_done_one_cycle", i), {Done, DivByZero, Busy}, 0);
        end

        // mthi / mtlo in IDLE.
        MtHi_EX = 1; SrcA_EX = 32'hA5A5_A5A5;
        @(negedge clk);
        MtHi_EX = 0; MtLo_EX = 1; SrcA_EX = 32'h1234_5678;
        check("mthi", Hi, 32'hA5A5_A5A5);
        @(negedge clk);
        MtLo_EX = 0;
        check("mtlo", Lo, 32'h1234_5678);
        check("mtlo_hi_kept", Hi, 32'hA5A5_A5A5);

        // Start with MtHi together: Start wins, Hi untouched right after.
        MtHi_EX = 1;
        Start_EX = 1; IsDiv_EX = 0; SrcA_EX = 32'd3; SrcB_EX = 32'd5;
        @(posedge clk);
        @(negedge clk);
        Start_EX = 0; MtHi_EX = 0;
        check("start_beats_mthi", Hi, 32'hA5A5_A5A5);
        // mfhi from cycle 2 plus an ignored mthi while busy.
        MfReq_EX = 1; MtHi_EX = 1; SrcA_EX = 32'hDEAD_BEEF;
        begin
            int stall_bad = 0;
            int c = 2;
            @(negedge clk);
            while (!Done && c < 40) begin
                if (MdStall !== 1'b1) stall_bad++;
                c++;
                @(negedge clk);
            end
            check("stall_while_busy_bad_cycles", stall_bad, 0);
            check("stall_done_latency", c, 34);
        end
        check("stall_released_in_done", MdStall, 0);
        check("mf_sees_lo", Lo, 32'h0000_000F);
        check("mthi_ignored_busy", Hi, 0);
        MfReq_EX = 0; MtHi_EX = 0;

        // Back-to-back: Start in the Done cycle of min/-1 divide.
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, dz);
        check("min_div_lo", Lo, 32'h8000_0000);
        check("min_div_hi", Hi, 0);
        Start_EX = 1; IsDiv_EX = 0; SrcA_EX = 32'd6; SrcB_EX = 32'd7;
        @(negedge clk);
        Start_EX = 0;
        check("b2b_accepted_busy", Busy, 1);
        for (int c = 0; c < 40 && !Done; c++) @(negedge clk);
        check("b2b_result_lo", Lo, 42);

        // Flush mid-RUN at counter=10, with non-zero HI/LO beforehand.
        @(negedge clk);
        MtHi_EX = 1; MtLo_EX = 1; SrcA_EX = 32'h5555_AAAA;
        @(negedge clk);
        MtHi_EX = 0; MtLo_EX = 0;
        Start_EX = 1; IsDiv_EX = 1; SrcA_EX = 32'd1000; SrcB_EX = 32'd3;
        @(negedge clk);
        Start_EX = 0;
        repeat (10) @(negedge clk);   // cycle 11 after start: counter = 10
        flush = 1; #1;
        check("flush_busy", Busy, 0);
        check("flush_hilo", {Hi, Lo}, 0);
        @(negedge clk);
        flush = 0;
        begin
            int done_seen = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (Done || Busy) done_seen++;
            end
            check("flush_no_done", done_seen, 0);
        end
        check("flush_hilo_after", {Hi, Lo}, 0);

        // Random ops vs reference model.
        for (int n = 0; n < 40; n++) begin
            logic         rd;
            logic [W-1:0] ra, rb;
            rd = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = '1;
                2: ra = 32'h8000_0000;
                3: rb = 32'(int'($urandom_range(0, 15)) - 8);
                default: ;
            endcase
            model(rd, ra, rb, eh, el, edz);
            run_op(rd, ra, rb, lat, bc, dz);
            check($sformatf("rnd%0d_lat", n), lat, 34);
            check($sformatf("rnd%0d_hi", n), Hi, eh);
            check($sformatf("rnd%0d_lo", n), Lo, el);
            check($sformatf("rnd%0d_dz", n), dz, edz);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
